// File: rtl/rv_fetch_unit.sv
// Instruction fetch: owns the PC, fetches over a req/valid handshake, and latches the IR for decode.
// Latency: 1 cycle RESET, FETCH holds until imem_valid, ISSUE holds until exec_done; optional FETCH_MISALIGN_TRAP_EN.
// Backpressure: imem_addr is held stable while imem_valid is low; IR is held until exec_done.
module rv_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [1:0]      PCSrc,
    input  logic [XLEN-1:0] ImmExt,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            exec_done,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instr,
    output logic            instr_valid,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [31:0]     retired,
    output logic            misalign_err
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_RESET, S_FETCH, S_ISSUE, S_ERROR} state_t;
    logic            err_q;
`else
    typedef enum logic [1:0] {S_RESET, S_FETCH, S_ISSUE} state_t;
`endif

    state_t          state;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] target_aligned;

    assign PCPlus4   = PC + XLEN'(4);
    assign imem_addr = PC;
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];

    always_comb begin
        target = PCPlus4;
        case (PCSrc)
            2'b01:   target = PC + ImmExt;
            2'b10:   target = ALUResult & ~XLEN'(1);
            default: target = PCPlus4;
        endcase
        target_aligned = target & ~XLEN'(3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_RESET;
            PC          <= RESET_PC;
            instr       <= 32'h0000_0013;
            instr_valid <= 1'b0;
            imem_req    <= 1'b0;
            retired     <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                S_RESET: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                end
                S_FETCH: begin
                    if (imem_valid) begin
                        instr       <= imem_rdata;
                        state       <= S_ISSUE;
                        imem_req    <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (exec_done) begin
                        retired     <= retired + 32'd1;
                        instr_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                        // A misaligned target parks the unit; PC keeps the faulting instruction's address.
                        if (target != target_aligned) begin
                            err_q <= 1'b1;
                            state <= S_ERROR;
                        end else begin
                            PC       <= target;
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                        end
`else
                        PC       <= target_aligned;
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_TRAP_EN
                S_ERROR: begin
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
`endif
                default: begin
                    state       <= S_RESET;
                    imem_req    <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    assign misalign_err = err_q;
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Bench for rv_fetch_unit: directed scenarios pinned by literals, then random traffic against a phase-level model.
module tb_rv_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  PCSrc = 2'b00;
    logic [31:0] ImmExt = '0;
    logic [31:0] ALUResult = '0;
    logic        exec_done = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] retired;
    logic        misalign_err;

    rv_fetch_unit #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .ImmExt(ImmExt), .ALUResult(ALUResult),
        .exec_done(exec_done), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instr(instr),
        .instr_valid(instr_valid), .PC(PC), .PCPlus4(PCPlus4), .opcode(opcode),
        .funct3(funct3), .retired(retired), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: phase 0 = just out of reset, 1 = waiting for memory, 2 = holding an instruction, 3 = trapped.
    int          m_phase;
    logic [31:0] m_pc, m_ir, m_ret;
    logic        m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pc = 32'h0; m_ir = 32'h0000_0013; m_ret = 0; m_err = 1'b0;
    endtask

    task automatic model_edge();
        logic [31:0] t;
        if (!rst_n) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 1) begin
            if (imem_valid) begin
                m_ir = imem_rdata;
                m_phase = 2;
            end
        end else if (m_phase == 2) begin
            if (exec_done) begin
                if (PCSrc == 2'd1)      t = m_pc + ImmExt;
                else if (PCSrc == 2'd2) t = ALUResult - (ALUResult % 2);
                else                    t = m_pc + 4;
                m_ret = m_ret + 1;
`ifdef FETCH_MISALIGN_TRAP_EN
                if (t % 4 != 0) begin
                    m_err = 1'b1;
                    m_phase = 3;
                end else begin
                    m_pc = t;
                    m_phase = 1;
                end
`else
                m_pc = t - (t % 4);
                m_phase = 1;
`endif
            end
        end
    endtask

    task automatic compare_all();
        chk("imem_req", {31'b0, imem_req}, {31'b0, m_phase == 1});
        chk("imem_addr", imem_addr, m_pc);
        chk("pc", PC, m_pc);
        chk("pcplus4", PCPlus4, m_pc + 4);
        chk("instr", instr, m_ir);
        chk("opcode", {25'b0, opcode}, {25'b0, m_ir[6:0]});
        chk("funct3", {29'b0, funct3}, {29'b0, m_ir[14:12]});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_phase == 2});
        chk("retired", retired, m_ret);
        chk("misalign_err", {31'b0, misalign_err}, {31'b0, m_err});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_exec(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] alu);
        PCSrc = s; ImmExt = imm; ALUResult = alu; exec_done = 1'b1;
        step();
        exec_done = 1'b0;
    endtask

    task automatic do_fetch(input logic [31:0] rdata);
        imem_valid = 1'b1; imem_rdata = rdata;
        step();
        imem_valid = 1'b0;
    endtask

    task automatic restart();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        model_reset();
        imem_valid = 1'b1;              // late valid during reset must be ignored
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        compare_all();
        step();
        chk("rst_pc", PC, 32'h0);
        chk("rst_instr", instr, 32'h0000_0013);
        chk("rst_opcode", {25'b0, opcode}, 32'h13);
        chk("rst_req", {31'b0, imem_req}, 32'h0);
        chk("rst_retired", retired, 32'h0);
        imem_valid = 1'b0;

        // First fetch answered immediately.
        rst_n = 1'b1;
        step();
        chk("t1_req", {31'b0, imem_req}, 32'h1);
        chk("t1_addr", imem_addr, 32'h0);
        do_fetch(32'h0050_0093);
        chk("t1_instr", instr, 32'h0050_0093);
        chk("t1_opcode", {25'b0, opcode}, 32'h13);
        chk("t1_valid", {31'b0, instr_valid}, 32'h1);

        // Sequential flow up to PC=0x10, then PC+4.
        for (int i = 0; i < 4; i++) begin
            do_exec(2'b00, 32'h0, 32'h0);
            do_fetch(32'h0000_0013);
        end
        chk("t2_pc_before", PC, 32'h10);
        do_exec(2'b00, 32'h0, 32'h0);
        chk("t2_addr", imem_addr, 32'h14);
        chk("t2_retired", retired, 32'd5);
        do_fetch(32'h0000_0013);

        // Branch backwards and jalr with bit 0 set.
        do_exec(2'b01, 32'h0000_000C, 32'h0);
        do_fetch(32'h0000_0013);
        chk("t3_pc20", PC, 32'h20);
        do_exec(2'b01, 32'hFFFF_FFF8, 32'h0);
        chk("t3_branch", imem_addr, 32'h18);
        do_fetch(32'h0000_0013);
        do_exec(2'b10, 32'h0, 32'h0000_0101);
        chk("t3_jalr", imem_addr, 32'h100);
        do_fetch(32'h0000_0013);

        // Memory stall with spurious exec_done pulses.
        do_exec(2'b11, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            exec_done = 1'b1; PCSrc = 2'b01; ImmExt = 32'h40;
            step();
            chk("t4_req", {31'b0, imem_req}, 32'h1);
            chk("t4_addr", imem_addr, 32'h104);
            chk("t4_retired", retired, 32'd9);
        end
        exec_done = 1'b0;
        do_fetch(32'h0000_0013);

        // Misaligned branch target from PC=0x8.
        do_exec(2'b10, 32'h0, 32'h8);
        do_fetch(32'h0000_0013);
        do_exec(2'b01, 32'h2, 32'h0);
        chk("t5_retired", retired, 32'd11);
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("t5_err", {31'b0, misalign_err}, 32'h1);
        chk("t5_req", {31'b0, imem_req}, 32'h0);
        step();
        chk("t5_req_hold", {31'b0, imem_req}, 32'h0);
`else
        chk("t5_addr", imem_addr, 32'h8);
        chk("t5_err", {31'b0, misalign_err}, 32'h0);
`endif

        // Asynchronous reset in the middle of a fetch at PC=0x40.
        restart();
        do_fetch(32'h0000_0013);
        do_exec(2'b10, 32'h0, 32'h40);
        chk("t6_addr", imem_addr, 32'h40);
        #2 rst_n = 1'b0;
        imem_valid = 1'b1;
        #1;
        chk("t6_async_req", {31'b0, imem_req}, 32'h0);
        chk("t6_async_pc", PC, 32'h0);
        step();
        imem_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("t6_pc", PC, 32'h0);
        chk("t6_retired", retired, 32'h0);

        // Random traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            if (!rst_n) rst_n = 1'b1;
            else if ($urandom_range(0, 299) == 0 || (m_phase == 3 && $urandom_range(0, 9) == 0)) rst_n = 1'b0;
            imem_valid = ($urandom_range(0, 1) == 1);
            imem_rdata = $urandom;
            exec_done  = ($urandom_range(0, 2) == 0);
            PCSrc      = 2'($urandom_range(0, 3));
            ImmExt     = ($urandom_range(0, 15) == 0) ? $urandom : ($urandom & 32'h0000_FFFC);
            ALUResult  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rv_fetch_unit.md
# rv_fetch_unit

Instruction-fetch stage of the single-cycle RISC-V core, directly upstream of the control unit. It owns the program counter and requests instructions from instruction memory over a valid handshake. It latches the returned instruction and presents it, with its `opcode`/`funct3` fields, to decode and control. When execute signals completion, it applies the control unit's `PCSrc` selection to form the next PC.

## Interface
Parameters:
- `XLEN`, 32: address/data width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `PCSrc`  in  2  next-PC select: 00 = PC+4, 01 = PC+`ImmExt`, 10 = `ALUResult` with bit 0 cleared, 11 = PC+4.
- `ImmExt`  in  XLEN  sign-extended immediate for branch/jal targets.
- `ALUResult`  in  XLEN  jalr target.
- `exec_done`  in  1  execute has consumed the current instruction; one-cycle pulse.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  XLEN  fetch address; equals `PC`.
- `imem_valid`  in  1  `imem_rdata` is valid this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction register (IR).
- `instr_valid`  out  1  IR holds an instruction not yet executed.
- `PC`  out  XLEN  address of the instruction in IR.
- `PCPlus4`  out  XLEN  `PC`+4, combinational, for jal/jalr writeback.
- `opcode`  out  7  `instr[6:0]`, combinational.
- `funct3`  out  3  `instr[14:12]`, combinational.
- `retired`  out  32  count of completed instructions.
- `misalign_err`  out  1  sticky misaligned-target flag; tied 0 when the feature is compiled out.

## Operation
- States:
  - RESET: one cycle after reset release; transitions to FETCH.
  - FETCH: `imem_req`=1 and `imem_addr`=`PC`. On `imem_valid`=1 at the edge: IR <= `imem_rdata`, go to ISSUE. Otherwise stay in FETCH with the address held stable.
  - ISSUE: `instr_valid`=1 and `imem_req`=0. On `exec_done`=1: PC <= next_pc, `retired` += 1 (wraps at 2^32), go to FETCH.
  - ERROR: exists only with the macro; see Configuration.
- next_pc:
  - Computed combinationally in ISSUE from `PCSrc`, `PC`, `ImmExt` and `ALUResult`.
  - Uses the `PCSrc` value present in the `exec_done` cycle.
  - Sums are XLEN-bit modulo; overflow wraps silently.
- Inputs are masked outside their states:
  - `exec_done` is ignored outside ISSUE.
  - `imem_valid` is ignored outside FETCH.
- IR keeps its value while in FETCH; `instr_valid` is 0 during FETCH.
- Reset values:
  - `PC`=`RESET_PC`, IR=32'h0000_0013 (nop), `instr_valid`=0, `imem_req`=0, `retired`=0, `misalign_err`=0.
  - `imem_addr`=`RESET_PC`, `opcode`=7'h13, `funct3`=0.
- Asserting `rst_n` mid-fetch drops `imem_req` immediately, without waiting for a clock edge. A late `imem_valid` is ignored.

## Timing
- Reset release edge is followed by 1 cycle in RESET, then `imem_req` rises.
- Fetch latency: if `imem_valid` is high in the first FETCH cycle, `instr_valid` rises in the next cycle.
- Throughput: at best 1 instruction per 2 cycles (FETCH, ISSUE), plus memory wait cycles.
- After `exec_done`, the new `PC`/`imem_addr` is visible the following cycle, with `imem_req`=1.
- All registered outputs change only on `clk` rising edges, except during asynchronous reset.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - If the selected next_pc has `[1:0]` != 0 when `exec_done` arrives, PC is not updated and `retired` still increments.
  - `misalign_err` is set (sticky) and the FSM enters ERROR.
  - In ERROR: `imem_req`=0 and `instr_valid`=0; the block stays there until reset.
- `FETCH_MISALIGN_TRAP_EN` undefined:
  - next_pc `[1:0]` is forced to 00.
  - There is no ERROR state; `misalign_err` is constant 0.

## Test plan
- Reset then `imem_valid` immediately with rdata=32'h00500093 -> `imem_addr`=0 in FETCH. Next cycle: `instr`=32'h00500093, `opcode`=7'h13, `instr_valid`=1.
- `PCSrc`=00 with `exec_done` at PC=0x10 -> next FETCH with `imem_addr`=0x14 and `retired` incremented by 1.
- `PCSrc`=01, `ImmExt`=32'hFFFF_FFF8 at PC=0x20 -> `imem_addr`=0x18. `PCSrc`=10, `ALUResult`=0x101 -> `imem_addr`=0x100.
- `imem_valid` held low for 5 FETCH cycles -> `imem_req`=1 and `imem_addr` stable throughout. `exec_done` pulses during FETCH have no effect on PC or `retired`.
- `rst_n` asserted mid-FETCH at PC=0x40 -> `imem_req`=0 immediately. After release: PC=`RESET_PC`, `retired`=0.
- `PCSrc`=01, `ImmExt`=0x2 at PC=0x8:
  - With macro: `misalign_err`=1, `imem_req` stays 0.
  - Without macro: `imem_addr`=0x8.
